// File: rtl/fwd_pkg.sv
// Shared constants for the forwarding/hazard controller: select codes,
// write-source encodings and shadow-entry field widths.
package fwd_pkg;

  localparam int SH_REG_W   = 3;
  localparam int SH_SRC_W   = 2;
  localparam int FWD_CODE_W = 3;

  localparam logic [FWD_CODE_W-1:0] FWD_RF        = 3'b000;
  localparam logic [FWD_CODE_W-1:0] FWD_MEMWB_WB  = 3'b001;
  localparam logic [FWD_CODE_W-1:0] FWD_EXMEM_ALU = 3'b010;
  localparam logic [FWD_CODE_W-1:0] FWD_EXMEM_PC  = 3'b011;
  localparam logic [FWD_CODE_W-1:0] FWD_MEMWB_PC  = 3'b100;

  localparam logic [SH_SRC_W-1:0] WSRC_ALU  = 2'b00;
  localparam logic [SH_SRC_W-1:0] WSRC_LOAD = 2'b01;
  localparam logic [SH_SRC_W-1:0] WSRC_LINK = 2'b10;
  localparam logic [SH_SRC_W-1:0] WSRC_ILL  = 2'b11;

  typedef struct packed {
    logic                  hazard;
    logic [FWD_CODE_W-1:0] sel;
  } fwd_res_t;

endpackage

// File: rtl/fwd_stage_reg.sv
// One shadow pipeline entry {vld, wr_en, wr_reg, wr_src}; holds while en==0,
// loads an invalid entry when bubble==1.
module fwd_stage_reg
  import fwd_pkg::*;
#(
  parameter int REG_W = SH_REG_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                bubble,
  input  logic                d_vld,
  input  logic                d_wr_en,
  input  logic [REG_W-1:0]    d_wr_reg,
  input  logic [SH_SRC_W-1:0] d_wr_src,
  output logic                q_vld,
  output logic                q_wr_en,
  output logic [REG_W-1:0]    q_wr_reg,
  output logic [SH_SRC_W-1:0] q_wr_src
);

  logic                vld_reg;
  logic                wr_en_reg;
  logic [REG_W-1:0]    wr_reg_reg;
  logic [SH_SRC_W-1:0] wr_src_reg;

  always_ff @(posedge clk) begin
    if (!rst) begin
      vld_reg    <= 1'b0;
      wr_en_reg  <= 1'b0;
      wr_reg_reg <= '0;
      wr_src_reg <= '0;
    end else if (en) begin
      vld_reg    <= d_vld & ~bubble;
      wr_en_reg  <= d_wr_en;
      wr_reg_reg <= d_wr_reg;
      wr_src_reg <= d_wr_src;
    end
  end

  assign q_vld    = vld_reg;
  assign q_wr_en  = wr_en_reg;
  assign q_wr_reg = wr_reg_reg;
  assign q_wr_src = wr_src_reg;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Decode-stage forwarding-select and load-use stall generator with EX/MEM/WB shadow entries.
// Define FWD_BYPASS_EN for full bypassing; otherwise dependents stall until the producer reaches WB.
module fwd_hazard_ctrl
  import fwd_pkg::*;
#(
  parameter int REG_W = SH_REG_W,
  parameter int FWD_W = FWD_CODE_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [REG_W-1:0]    id_rs,
  input  logic                id_rs_used,
  input  logic [REG_W-1:0]    id_rt,
  input  logic                id_rt_used,
  input  logic                id_wr_en,
  input  logic [REG_W-1:0]    id_wr_reg,
  input  logic [SH_SRC_W-1:0] id_wr_src,
  input  logic                flush,
  input  logic                mem_stall,
  output logic                stall,
  output logic [FWD_W-1:0]    forwardA,
  output logic [FWD_W-1:0]    forwardB,
  output logic                ex_vld,
  output logic                mem_vld,
  output logic                wb_vld,
  output logic                err
);

  // Index 0 = EX, 1 = MEM, 2 = WB.
  logic [2:0]          st_vld;
  logic [2:0]          st_wen;
  logic [REG_W-1:0]    st_reg [3];
  logic [SH_SRC_W-1:0] st_src [3];

  logic       bubble_ex;
  fwd_res_t   res_a;
  fwd_res_t   res_b;
  logic [FWD_W-1:0] fwd_a_reg;
  logic [FWD_W-1:0] fwd_b_reg;
  logic       err_reg;

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_stage
      if (gi == 0) begin : g_ex
        fwd_stage_reg #(.REG_W(REG_W)) u_stage (
          .clk      (clk),
          .rst      (rst),
          .en       (~mem_stall),
          .bubble   (bubble_ex),
          .d_vld    (id_valid),
          .d_wr_en  (id_wr_en),
          .d_wr_reg (id_wr_reg),
          .d_wr_src (id_wr_src),
          .q_vld    (st_vld[gi]),
          .q_wr_en  (st_wen[gi]),
          .q_wr_reg (st_reg[gi]),
          .q_wr_src (st_src[gi])
        );
      end else begin : g_older
        fwd_stage_reg #(.REG_W(REG_W)) u_stage (
          .clk      (clk),
          .rst      (rst),
          .en       (~mem_stall),
          .bubble   (1'b0),
          .d_vld    (st_vld[gi-1]),
          .d_wr_en  (st_wen[gi-1]),
          .d_wr_reg (st_reg[gi-1]),
          .d_wr_src (st_src[gi-1]),
          .q_vld    (st_vld[gi]),
          .q_wr_en  (st_wen[gi]),
          .q_wr_reg (st_reg[gi]),
          .q_wr_src (st_src[gi])
        );
      end
    end
  endgenerate

  // WB only needs to exist as a shadow; the regfile writes through, so it never drives a select.
  logic unused_shadow;
  assign unused_shadow = ^{st_wen[2], st_reg[2], st_src[0], st_src[1], st_src[2]};

  // EX is checked first so the youngest producer wins.
  function automatic fwd_res_t resolve(input logic [REG_W-1:0] src, input logic used);
    fwd_res_t r;
    logic     m_ex;
    logic     m_mem;
    r     = '0;
    m_ex  = used & st_vld[0] & st_wen[0] & (st_reg[0] == src);
    m_mem = used & st_vld[1] & st_wen[1] & (st_reg[1] == src);
`ifdef FWD_BYPASS_EN
    if (m_ex) begin
      r.hazard = (st_src[0] == WSRC_LOAD);
      case (st_src[0])
        WSRC_ALU:  r.sel = FWD_EXMEM_ALU;
        WSRC_LINK: r.sel = FWD_EXMEM_PC;
        default:   r.sel = FWD_RF;
      endcase
    end else if (m_mem) begin
      case (st_src[1])
        WSRC_ALU, WSRC_LOAD: r.sel = FWD_MEMWB_WB;
        WSRC_LINK:           r.sel = FWD_MEMWB_PC;
        default:             r.sel = FWD_RF;
      endcase
    end
`else
    r.hazard = m_ex | m_mem;
    r.sel    = FWD_RF;
`endif
    return r;
  endfunction

  always_comb begin
    res_a     = resolve(id_rs, id_rs_used);
    res_b     = resolve(id_rt, id_rt_used);
    stall     = id_valid & (res_a.hazard | res_b.hazard) & ~flush;
    bubble_ex = stall | flush | ~id_valid;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      fwd_a_reg <= '0;
      fwd_b_reg <= '0;
      err_reg   <= 1'b0;
    end else begin
      if (id_valid & id_wr_en & (id_wr_src == WSRC_ILL))
        err_reg <= 1'b1;
      if (!mem_stall) begin
        fwd_a_reg <= bubble_ex ? '0 : FWD_W'(res_a.sel);
        fwd_b_reg <= bubble_ex ? '0 : FWD_W'(res_b.sel);
      end
    end
  end

  assign forwardA = fwd_a_reg;
  assign forwardB = fwd_b_reg;
  assign ex_vld   = st_vld[0];
  assign mem_vld  = st_vld[1];
  assign wb_vld   = st_vld[2];
  assign err      = err_reg;

endmodule
